// File: rtl/motor_pwm_state_ctrl.sv
// Motor speed state, PWM generator and seconds countdown driven by speed/stop/timer buttons.
// Optional input conditioning (synchronizer + debouncer) enabled by MOTOR_PWM_STATE_CTRL_DEBOUNCE_EN.
module motor_pwm_state_ctrl #(
   parameter int PWM_PERIOD_CYC = 1000,
   parameter int TICK_CYC       = 100_000_000,
   parameter int TIMER_SEC      = 10,
   parameter int DEB_CYC        = 1_000_000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_btn_speed,
   input  logic       i_btn_stop,
   input  logic       i_btn_timer,
   output logic [2:0] o_pwm_state,
   output logic       o_pwm,
   output logic       o_timer_active,
   output logic [7:0] o_time_left
);

   localparam int BTN_SPEED = 0;
   localparam int BTN_STOP  = 1;
   localparam int BTN_TIMER = 2;

   localparam int TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_CYC - 1);
   localparam logic [7:0] TIMER_LOAD = 8'(TIMER_SEC);

   localparam int PWM_W   = $clog2(PWM_PERIOD_CYC + 1);
   localparam int QUARTER = PWM_PERIOD_CYC / 4;
   localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_PERIOD_CYC - 1);
   localparam logic [PWM_W-1:0] DUTY_Q1  = PWM_W'(QUARTER);
   localparam logic [PWM_W-1:0] DUTY_Q2  = PWM_W'(QUARTER * 2);
   localparam logic [PWM_W-1:0] DUTY_Q3  = PWM_W'(QUARTER * 3);
   localparam logic [PWM_W-1:0] DUTY_Q4  = PWM_W'(QUARTER * 4);

   typedef enum logic [2:0] {
      ST_OFF  = 3'd0,
      ST_SPD1 = 3'd1,
      ST_SPD2 = 3'd2,
      ST_SPD3 = 3'd3,
      ST_SPD4 = 3'd4
   } state_t;

   function automatic state_t step_speed(input state_t s);
      case (s)
         ST_OFF:  return ST_SPD1;
         ST_SPD1: return ST_SPD2;
         ST_SPD2: return ST_SPD3;
         ST_SPD3: return ST_SPD4;
         default: return ST_OFF;
      endcase
   endfunction

   function automatic logic [PWM_W-1:0] duty_of(input state_t s);
      case (s)
         ST_SPD1: return DUTY_Q1;
         ST_SPD2: return DUTY_Q2;
         ST_SPD3: return DUTY_Q3;
         ST_SPD4: return DUTY_Q4;
         default: return '0;
      endcase
   endfunction

   logic [2:0] btn_raw;
   logic [2:0] btn_lvl;
   logic [2:0] btn_prev;
   logic [2:0] btn_ev;

   assign btn_raw = {i_btn_timer, i_btn_stop, i_btn_speed};

`ifdef MOTOR_PWM_STATE_CTRL_DEBOUNCE_EN
   localparam int DEB_W = $clog2(DEB_CYC + 1);

   // Input conditioning: 2-FF synchronizer then a stable-count debouncer
   for (genvar g = 0; g < 3; g++) begin : g_deb
      logic             sync_p0;
      logic             sync_p1;
      logic             deb_q;
      logic [DEB_W-1:0] deb_cnt;

      always_ff @(posedge i_clk or posedge i_reset) begin
         if (i_reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            deb_q   <= 1'b0;
            deb_cnt <= '0;
         end else begin
            sync_p0 <= btn_raw[g];
            sync_p1 <= sync_p0;
            if (sync_p1 == deb_q) begin
               deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
               deb_q   <= sync_p1;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + DEB_W'(1);
            end
         end
      end

      assign btn_lvl[g] = deb_q;
   end
`else
   assign btn_lvl = btn_raw;
`endif

   assign btn_ev = btn_lvl & ~btn_prev;

   state_t            state_q;
   state_t            state_d;
   logic              active_q;
   logic              active_d;
   logic [7:0]        left_q;
   logic [7:0]        left_d;
   logic [TICK_W-1:0] tick_q;
   logic [TICK_W-1:0] tick_d;
   logic              tick_wrap;
   logic              expiry;

   // Control registers: edge history, speed state, countdown
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         btn_prev <= '0;
         state_q  <= ST_OFF;
         active_q <= 1'b0;
         left_q   <= '0;
         tick_q   <= '0;
      end else begin
         btn_prev <= btn_lvl;
         state_q  <= state_d;
         active_q <= active_d;
         left_q   <= left_d;
         tick_q   <= tick_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      left_d    = left_q;
      tick_wrap = active_q && (tick_q == TICK_MAX);
      expiry    = tick_wrap && (left_q == 8'd1);

      if (btn_ev[BTN_STOP] || expiry) begin
         state_d  = ST_OFF;
         active_d = 1'b0;
         left_d   = '0;
      end else begin
         if (tick_wrap) begin
            left_d = left_q - 8'd1;
         end
         if (btn_ev[BTN_SPEED]) begin
            state_d = step_speed(state_q);
            // Wrapping back to off also drops any running countdown
            if (state_d == ST_OFF) begin
               active_d = 1'b0;
               left_d   = '0;
            end
         end else if (btn_ev[BTN_TIMER] && (state_q != ST_OFF)) begin
            if (active_q) begin
               active_d = 1'b0;
               left_d   = '0;
            end else begin
               active_d = 1'b1;
               left_d   = TIMER_LOAD;
            end
         end
      end

      if (!active_d || !active_q || tick_wrap) begin
         tick_d = '0;
      end else begin
         tick_d = tick_q + TICK_W'(1);
      end
   end

   logic [PWM_W-1:0] pwm_cnt_q;
   state_t           latched_q;
   logic             pwm_q;

   // PWM stage: duty follows the state only at period boundaries, except off is immediate
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pwm_cnt_q <= '0;
         latched_q <= ST_OFF;
         pwm_q     <= 1'b0;
      end else begin
         pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_W'(1);
         if (state_d == ST_OFF) begin
            latched_q <= ST_OFF;
            pwm_q     <= 1'b0;
         end else begin
            if (pwm_cnt_q == PWM_LAST) begin
               latched_q <= state_q;
            end
            pwm_q <= (pwm_cnt_q < duty_of(latched_q));
         end
      end
   end

   assign o_pwm_state    = state_q;
   assign o_pwm          = pwm_q;
   assign o_timer_active = active_q;
   assign o_time_left    = left_q;

endmodule
